wm_ctrl: RTL and testbench

- Store-side memory controller in the MEM stage; the write counterpart of the load data-extraction path.
- Accepts a store (sb/sh/sw) from the pipeline and checks alignment.
- Builds big-endian byte lane selects and positioned write data.
- Runs a req/ack handshake to data memory, stalling the pipeline until ack, timeout, or exception.

---
 rtl/wm_ctrl_if.sv | 47 ++++
 rtl/wm_ctrl.sv | 144 ++++++++++++++
 tb/tb_wm_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wm_ctrl_if.sv
// Data-memory write bus between the store controller (master) and memory (slave).
// Shared opcode and lane-width macros live here so every user sees one definition.
`ifndef OpcodeWidth
`define OpcodeWidth 6
`endif
`ifndef ByteSlctWidth
`define ByteSlctWidth 4
`endif
`ifndef MIPS_SB
`define MIPS_SB 6'b101000
`endif
`ifndef MIPS_SH
`define MIPS_SH 6'b101001
`endif
`ifndef MIPS_SW
`define MIPS_SW 6'b101011
`endif

interface wm_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                      mem_req;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [`ByteSlctWidth-1:0] mem_byte_slct;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_byte_slct,
      output mem_wdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_byte_slct,
      input  mem_wdata,
      output mem_ack
   );
endinterface

// File: rtl/wm_ctrl.sv
// MEM-stage store controller: alignment check, big-endian lane steering and a
// req/ack write handshake that stalls the pipeline until ack, timeout or exception.
module wm_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    st_valid,
   input  logic [`OpcodeWidth-1:0] opcode,
   input  logic [ADDR_W-1:0]       st_addr,
   input  logic [DATA_W-1:0]       st_data,
   output logic                    stall,
   output logic                    done,
   output logic                    excp_ades,
   output logic                    bus_err,
   wm_ctrl_if.master               bus
);
   localparam int                NUM_LANES = DATA_W / 8;
   localparam int                CNT_W     = $clog2(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                     r_state;
   state_t                     w_state;
   logic [CNT_W-1:0]           r_cnt;
   logic [CNT_W-1:0]           w_cnt;
   logic                       r_req;
   logic [ADDR_W-1:0]          r_addr;
   logic [`ByteSlctWidth-1:0]  r_slct;
   logic [DATA_W-1:0]          r_wdata;

   logic                       w_is_sb;
   logic                       w_is_sh;
   logic                       w_is_sw;
   logic                       w_is_store;
   logic                       w_misaligned;
   logic                       w_accept;
   logic                       w_release;
   logic [`ByteSlctWidth-1:0]  w_slct;
   logic [DATA_W-1:0]          w_wdata;

   assign w_is_sb    = (opcode == `MIPS_SB);
   assign w_is_sh    = (opcode == `MIPS_SH);
   assign w_is_sw    = (opcode == `MIPS_SW);
   assign w_is_store = st_valid & (w_is_sb | w_is_sh | w_is_sw);

   assign w_misaligned = (w_is_sh & st_addr[0]) |
                         (w_is_sw & (st_addr[1:0] != 2'b00));

   // Lane gi covers st bits [8*gi+7:8*gi]; lane 3 is the lowest byte address.
   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         localparam logic [1:0] SB_OFS  = 2'(NUM_LANES - 1 - gi);
         localparam logic       HI_HALF = (gi >= NUM_LANES / 2);

         assign w_slct[gi] = w_is_sw |
                             (w_is_sh & (st_addr[1] ^ HI_HALF)) |
                             (w_is_sb & (st_addr[1:0] == SB_OFS));

         assign w_wdata[8*gi +: 8] = !w_slct[gi] ? 8'h00 :
                                     w_is_sw     ? st_data[8*gi +: 8] :
                                     w_is_sh     ? st_data[8*(gi%2) +: 8] :
                                                   st_data[7:0];
      end
   endgenerate

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_accept  = 1'b0;
      w_release = 1'b0;
      stall     = 1'b0;
      done      = 1'b0;
      excp_ades = 1'b0;
      bus_err   = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (w_is_store) begin
                  if (w_misaligned) begin
                     excp_ades = 1'b1;
                  end else begin
                     stall    = 1'b1;
                     w_accept = 1'b1;
                     w_cnt    = '0;
                     w_state  = REQ;
                  end
               end
            end
            REQ: begin
               // Ack takes priority over a simultaneous timeout.
               if (bus.mem_ack) begin
                  done      = 1'b1;
                  w_release = 1'b1;
                  w_state   = IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  bus_err   = 1'b1;
                  w_release = 1'b1;
                  w_state   = IDLE;
               end else begin
                  stall = 1'b1;
                  w_cnt = r_cnt + CNT_W'(1);
               end
            end
            default: w_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_slct  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         if (w_accept) begin
            r_req   <= 1'b1;
            r_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            r_slct  <= w_slct;
            r_wdata <= w_wdata;
         end else if (w_release) begin
            r_req <= 1'b0;
         end
      end
   end

   assign bus.mem_req       = r_req;
   assign bus.mem_we        = r_req;
   assign bus.mem_addr      = r_addr;
   assign bus.mem_byte_slct = r_slct;
   assign bus.mem_wdata     = r_wdata;

endmodule

// File: tb/tb_wm_ctrl.sv
// Directed bench for wm_ctrl: table of single-store vectors plus hand-written
// sequences for multi-cycle ack, timeout and reset-during-request.
`ifndef OpcodeWidth
`define OpcodeWidth 6
`endif
`ifndef MIPS_SB
`define MIPS_SB 6'b101000
`endif
`ifndef MIPS_SH
`define MIPS_SH 6'b101001
`endif
`ifndef MIPS_SW
`define MIPS_SW 6'b101011
`endif

module tb_wm_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TMO    = 4;
   localparam logic [5:0] OP_LW = 6'b100011;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    st_valid;
   logic [`OpcodeWidth-1:0] opcode;
   logic [ADDR_W-1:0]       st_addr;
   logic [DATA_W-1:0]       st_data;
   logic                    stall;
   logic                    done;
   logic                    excp_ades;
   logic                    bus_err;

   wm_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   wm_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .opcode    (opcode),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .stall     (stall),
      .done      (done),
      .excp_ades (excp_ades),
      .bus_err   (bus_err),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = ignored, 1 = accepted, 2 = address error
   typedef struct {
      logic        valid;
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      int          kind;
      logic [31:0] maddr;
      logic [3:0]  slct;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, `MIPS_SB, 32'h0000_0101, 32'h1234_5678, 1, 32'h0000_0100, 4'b0100, 32'h0078_0000};
      vecs[1]  = '{1'b1, `MIPS_SB, 32'h0000_0100, 32'h1234_5678, 1, 32'h0000_0100, 4'b1000, 32'h7800_0000};
      vecs[2]  = '{1'b1, `MIPS_SB, 32'h0000_0102, 32'h1234_5678, 1, 32'h0000_0100, 4'b0010, 32'h0000_7800};
      vecs[3]  = '{1'b1, `MIPS_SB, 32'h0000_0103, 32'h1234_5678, 1, 32'h0000_0100, 4'b0001, 32'h0000_0078};
      vecs[4]  = '{1'b1, `MIPS_SH, 32'h0000_200A, 32'hABCD_1234, 1, 32'h0000_2008, 4'b0011, 32'h0000_1234};
      vecs[5]  = '{1'b1, `MIPS_SH, 32'h0000_2008, 32'hABCD_1234, 1, 32'h0000_2008, 4'b1100, 32'h1234_0000};
      vecs[6]  = '{1'b1, `MIPS_SW, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b1, `MIPS_SW, 32'h0000_0012, 32'hDEAD_BEEF, 2, 32'h0, 4'b0000, 32'h0};
      vecs[8]  = '{1'b1, `MIPS_SH, 32'h0000_0013, 32'hDEAD_BEEF, 2, 32'h0, 4'b0000, 32'h0};
      vecs[9]  = '{1'b1, `MIPS_SW, 32'h0000_0011, 32'hDEAD_BEEF, 2, 32'h0, 4'b0000, 32'h0};
      vecs[10] = '{1'b1, OP_LW,    32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 4'b0000, 32'h0};
      vecs[11] = '{1'b0, `MIPS_SW, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 4'b0000, 32'h0};

      // Reset: a store and an ack are presented but must be ignored.
      rst = 1'b1; st_valid = 1'b1; opcode = `MIPS_SW; st_addr = 32'h10; st_data = 32'hDEADBEEF;
      bus.mem_ack = 1'b1;
      tick(); tick(); #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_ades", {31'b0, excp_ades}, 32'd0);
      chk("rst_buserr", {31'b0, bus_err}, 32'd0);
      chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_slct", {28'b0, bus.mem_byte_slct}, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      $display("reset: stall=%0b mem_req=%0b", stall, bus.mem_req);
      rst = 1'b0; st_valid = 1'b0; bus.mem_ack = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         st_valid = vecs[i].valid; opcode = vecs[i].op;
         st_addr = vecs[i].addr; st_data = vecs[i].data; bus.mem_ack = 1'b0;
         #1;
         chk("vec_stall", {31'b0, stall}, {31'b0, vecs[i].kind == 1});
         chk("vec_ades", {31'b0, excp_ades}, {31'b0, vecs[i].kind == 2});
         chk("vec_done", {31'b0, done}, 32'd0);
         tick();
         st_valid = 1'b0;
         #1;
         chk("vec_req", {31'b0, bus.mem_req}, {31'b0, vecs[i].kind == 1});
         if (vecs[i].kind == 1) begin
            chk("vec_we", {31'b0, bus.mem_we}, 32'd1);
            chk("vec_addr", bus.mem_addr, vecs[i].maddr);
            chk("vec_slct", {28'b0, bus.mem_byte_slct}, {28'b0, vecs[i].slct});
            chk("vec_wdata", bus.mem_wdata, vecs[i].wdata);
            bus.mem_ack = 1'b1;
            #1;
            chk("vec_ack_done", {31'b0, done}, 32'd1);
            chk("vec_ack_stall", {31'b0, stall}, 32'd0);
            chk("vec_ack_buserr", {31'b0, bus_err}, 32'd0);
            tick();
            bus.mem_ack = 1'b0;
            #1;
            chk("vec_req_drop", {31'b0, bus.mem_req}, 32'd0);
         end
         $display("vec %0d op=%02h addr=%08h slct=%04b wdata=%08h ades=%0b errors=%0d",
                  i, vecs[i].op, vecs[i].addr, bus.mem_byte_slct, bus.mem_wdata, excp_ades, errors);
         tick();
      end

      // sw with ack in the 4th REQ cycle, which is also the timeout cycle: ack wins.
      st_valid = 1'b1; opcode = `MIPS_SW; st_addr = 32'h10; st_data = 32'hDEADBEEF;
      #1;
      chk("slow_accept_stall", {31'b0, stall}, 32'd1);
      tick();
      for (int c = 1; c <= TMO; c++) begin
         st_valid = (c < TMO); opcode = `MIPS_SB; st_addr = 32'h3; st_data = 32'h0;
         bus.mem_ack = (c == TMO);
         #1;
         chk("slow_req", {31'b0, bus.mem_req}, 32'd1);
         chk("slow_addr", bus.mem_addr, 32'h0000_0010);
         chk("slow_slct", {28'b0, bus.mem_byte_slct}, 32'hF);
         chk("slow_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
         chk("slow_stall", {31'b0, stall}, {31'b0, c < TMO});
         chk("slow_done", {31'b0, done}, {31'b0, c == TMO});
         chk("slow_buserr", {31'b0, bus_err}, 32'd0);
         tick();
      end
      bus.mem_ack = 1'b0; st_valid = 1'b0;
      #1;
      chk("slow_req_drop", {31'b0, bus.mem_req}, 32'd0);
      $display("slow ack sw: done in cycle %0d errors=%0d", TMO, errors);
      tick();

      // sw with no ack: bus error in the last REQ cycle.
      st_valid = 1'b1; opcode = `MIPS_SW; st_addr = 32'h20; st_data = 32'hCAFEF00D;
      tick();
      st_valid = 1'b0;
      for (int c = 1; c <= TMO; c++) begin
         #1;
         chk("tmo_req", {31'b0, bus.mem_req}, 32'd1);
         chk("tmo_buserr", {31'b0, bus_err}, {31'b0, c == TMO});
         chk("tmo_stall", {31'b0, stall}, {31'b0, c < TMO});
         chk("tmo_done", {31'b0, done}, 32'd0);
         tick();
      end
      #1;
      chk("tmo_req_drop", {31'b0, bus.mem_req}, 32'd0);
      chk("tmo_buserr_once", {31'b0, bus_err}, 32'd0);
      bus.mem_ack = 1'b1;
      #1;
      chk("tmo_late_ack", {31'b0, done}, 32'd0);
      $display("timeout sw: bus_err after %0d cycles errors=%0d", TMO, errors);
      tick();
      bus.mem_ack = 1'b0;

      // Reset in the 2nd REQ cycle, then a stray ack.
      st_valid = 1'b1; opcode = `MIPS_SB; st_addr = 32'h101; st_data = 32'hA5;
      tick();
      st_valid = 1'b0;
      #1;
      chk("rr_req1", {31'b0, bus.mem_req}, 32'd1);
      chk("rr_stall1", {31'b0, stall}, 32'd1);
      tick();
      rst = 1'b1;
      #1;
      chk("rr_rst_stall", {31'b0, stall}, 32'd0);
      chk("rr_rst_done", {31'b0, done}, 32'd0);
      tick();
      rst = 1'b0; bus.mem_ack = 1'b1;
      #1;
      chk("rr_req_after", {31'b0, bus.mem_req}, 32'd0);
      chk("rr_ack_done", {31'b0, done}, 32'd0);
      chk("rr_ack_stall", {31'b0, stall}, 32'd0);
      tick();
      bus.mem_ack = 1'b0;
      st_valid = 1'b1; opcode = `MIPS_SB; st_addr = 32'h103; st_data = 32'hA5;
      #1;
      chk("rr_next_stall", {31'b0, stall}, 32'd1);
      tick();
      st_valid = 1'b0;
      #1;
      chk("rr_next_req", {31'b0, bus.mem_req}, 32'd1);
      chk("rr_next_addr", bus.mem_addr, 32'h0000_0100);
      chk("rr_next_slct", {28'b0, bus.mem_byte_slct}, 32'h1);
      chk("rr_next_wdata", bus.mem_wdata, 32'h0000_00A5);
      bus.mem_ack = 1'b1;
      #1;
      chk("rr_next_done", {31'b0, done}, 32'd1);
      tick();
      bus.mem_ack = 1'b0;
      #1;
      chk("rr_next_drop", {31'b0, bus.mem_req}, 32'd0);
      $display("reset in REQ then sb: errors=%0d", errors);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
